// File: rtl/two_ops_pipe.sv
// two_ops_pipe: two-stage valid/ready pipeline computing a = (z + x) - z
// modulo 2^WIDTH, which always reproduces x. Stage 1 registers the sum and
// a copy of z; stage 2 performs the subtraction as s + ~z + 1.
// Optional build macro: TWO_OPS_CARRY_EN adds the cout/bout flag outputs.
module two_ops_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] a,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready
`ifdef TWO_OPS_CARRY_EN
    ,
    output logic             cout,
    output logic             bout
`endif
);

    logic             r_v1;
    logic             r_v2;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_zc;
    logic [WIDTH-1:0] r_a;
    logic             w_ld1;
    logic             w_ld2;
    logic             w_acc;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;

    // Load conditions; in_ready is held low while reset is asserted so the
    // first acceptance happens on the first edge after release.
    always_comb begin
        w_ld2    = !r_v2 || out_ready;
        w_ld1    = !r_v1 || w_ld2;
        in_ready = ASYNCRESETN && w_ld1;
        w_acc    = in_valid && in_ready;
    end

    // Stage arithmetic, one bit wider to expose the carries
    always_comb begin
        w_sum  = {1'b0, z} + {1'b0, x};
        w_diff = {1'b0, r_s} + {1'b0, ~r_zc} + {{WIDTH{1'b0}}, 1'b1};
    end

    // Stage 1: register sum, copy of z and valid bit
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_v1 <= 1'b0;
            r_s  <= '0;
            r_zc <= '0;
        end else if (w_ld1) begin
            r_v1 <= w_acc;
            r_s  <= w_sum[WIDTH-1:0];
            r_zc <= z;
        end
    end

    // Stage 2: register difference and output valid bit
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_v2 <= 1'b0;
            r_a  <= '0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            r_a  <= w_diff[WIDTH-1:0];
        end
    end

`ifdef TWO_OPS_CARRY_EN
    logic r_c1;
    logic r_cout;
    logic r_bout;

    // Carry of z + x travels with stage 1 data
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_c1 <= 1'b0;
        end else if (w_ld1) begin
            r_c1 <= w_sum[WIDTH];
        end
    end

    // Flags aligned with a; borrow is the inverted subtract carry
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_cout <= 1'b0;
            r_bout <= 1'b0;
        end else if (w_ld2) begin
            r_cout <= r_c1;
            r_bout <= ~w_diff[WIDTH];
        end
    end

    assign cout = r_cout;
    assign bout = r_bout;
`endif

    assign a         = r_a;
    assign out_valid = r_v2;

endmodule

// File: tb/tb_two_ops_pipe.sv
// Directed and randomised bench for two_ops_pipe (WIDTH = 8).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_two_ops_pipe;

    logic       CLK = 1'b0;
    logic       ASYNCRESETN = 1'b0;
    logic [7:0] z = '0;
    logic [7:0] x = '0;
    logic [7:0] a;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
`ifdef TWO_OPS_CARRY_EN
    logic       cout;
    logic       bout;
`endif

    int n_vec = 0;
    int n_err = 0;

    two_ops_pipe #(.WIDTH(8)) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .z          (z),
        .x          (x),
        .a          (a),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef TWO_OPS_CARRY_EN
        ,
        .cout       (cout),
        .bout       (bout)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (a !== 8'h00) begin n_err++; $display("FAIL rst_a: got %h expected 00", a); end
        in_valid = 1'b1; out_ready = 1'b1; z = 8'h33; x = 8'h44;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        @(negedge CLK); @(negedge CLK);
        ASYNCRESETN = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
        @(negedge CLK);
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_lat1: got %b expected 0", out_valid); end
        @(negedge CLK); #1;
        n_vec++; if (out_valid !== 1'b1 || a !== 8'h44) begin n_err++; $display("FAIL rst_first_result: got v=%b a=%h expected v=1 a=44", out_valid, a); end
        @(negedge CLK); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_basic();
        @(negedge CLK);
        z = 8'h10; x = 8'h25; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0; #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat1: got %b expected 0", out_valid); end
        @(negedge CLK); #1;
        n_vec++; if (out_valid !== 1'b1 || a !== 8'h25) begin n_err++; $display("FAIL basic_a: got v=%b a=%h expected v=1 a=25", out_valid, a); end
    endtask

    task automatic test_wrap();
        @(negedge CLK);
        z = 8'hF0; x = 8'h20; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        z = 8'h00; x = 8'hFF;
        @(negedge CLK);
        in_valid = 1'b0; #1;
        n_vec++; if (out_valid !== 1'b1 || a !== 8'h20) begin n_err++; $display("FAIL wrap_a: got v=%b a=%h expected v=1 a=20", out_valid, a); end
`ifdef TWO_OPS_CARRY_EN
        n_vec++; if (cout !== 1'b1 || bout !== 1'b1) begin n_err++; $display("FAIL wrap_flags: got cout=%b bout=%b expected 1 1", cout, bout); end
`endif
        @(negedge CLK); #1;
        n_vec++; if (out_valid !== 1'b1 || a !== 8'hFF) begin n_err++; $display("FAIL nowrap_a: got v=%b a=%h expected v=1 a=ff", out_valid, a); end
`ifdef TWO_OPS_CARRY_EN
        n_vec++; if (cout !== 1'b0 || bout !== 1'b0) begin n_err++; $display("FAIL nowrap_flags: got cout=%b bout=%b expected 0 0", cout, bout); end
`endif
        @(negedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        z = 8'h01; x = 8'hA1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        z = 8'h80; x = 8'hA2; out_ready = 1'b0; #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_second_ready: got %b expected 1", in_ready); end
        @(negedge CLK);
        z = 8'hFF; x = 8'hA3; #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %b expected 0", in_ready); end
        n_vec++; if (out_valid !== 1'b1 || a !== 8'hA1) begin n_err++; $display("FAIL b2b_hold1: got v=%b a=%h expected v=1 a=a1", out_valid, a); end
        @(negedge CLK); #1;
        n_vec++; if (out_valid !== 1'b1 || a !== 8'hA1 || in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_hold2: got v=%b a=%h rdy=%b expected v=1 a=a1 rdy=0", out_valid, a, in_ready); end
        out_ready = 1'b1; #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_release_ready: got %b expected 1", in_ready); end
        @(negedge CLK);
        z = 8'h7F; x = 8'hA4; #1;
        n_vec++; if (out_valid !== 1'b1 || a !== 8'hA2) begin n_err++; $display("FAIL b2b_r2: got v=%b a=%h expected v=1 a=a2", out_valid, a); end
        @(negedge CLK);
        in_valid = 1'b0; #1;
        n_vec++; if (out_valid !== 1'b1 || a !== 8'hA3) begin n_err++; $display("FAIL b2b_r3: got v=%b a=%h expected v=1 a=a3", out_valid, a); end
        @(negedge CLK); #1;
        n_vec++; if (out_valid !== 1'b1 || a !== 8'hA4) begin n_err++; $display("FAIL b2b_r4: got v=%b a=%h expected v=1 a=a4", out_valid, a); end
        @(negedge CLK); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_full_shift();
        @(negedge CLK);
        z = 8'h11; x = 8'hB1; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge CLK);
        z = 8'h22; x = 8'hB2;
        @(negedge CLK);
        z = 8'h33; x = 8'hB3; out_ready = 1'b1; #1;
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || a !== 8'hB1) begin n_err++; $display("FAIL shift_full: got rdy=%b v=%b a=%h expected rdy=1 v=1 a=b1", in_ready, out_valid, a); end
        @(negedge CLK);
        in_valid = 1'b0; #1;
        n_vec++; if (out_valid !== 1'b1 || a !== 8'hB2) begin n_err++; $display("FAIL shift_next: got v=%b a=%h expected v=1 a=b2", out_valid, a); end
        @(negedge CLK); #1;
        n_vec++; if (out_valid !== 1'b1 || a !== 8'hB3) begin n_err++; $display("FAIL shift_nobubble: got v=%b a=%h expected v=1 a=b3", out_valid, a); end
        @(negedge CLK); #1;
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        z = 8'h01; x = 8'h5A; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge CLK);
        x = 8'h5B;
        @(negedge CLK);
        in_valid = 1'b0; #1;
        n_vec++; if (out_valid !== 1'b1 || a !== 8'h5A) begin n_err++; $display("FAIL arst_pre: got v=%b a=%h expected v=1 a=5a", out_valid, a); end
        #1; ASYNCRESETN = 1'b0; #1;
        n_vec++; if (out_valid !== 1'b0 || a !== 8'h00 || in_ready !== 1'b0) begin n_err++; $display("FAIL arst_immediate: got v=%b a=%h rdy=%b expected v=0 a=00 rdy=0", out_valid, a, in_ready); end
        @(negedge CLK);
        ASYNCRESETN = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_stale: cycle %0d got v=%b expected 0", i, out_valid); end
            @(negedge CLK);
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] exp_x;
        int n_in = 0;
        int n_out = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge CLK);
            z = 8'($urandom); x = 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rand_spurious: cycle %0d got a=%h expected no result", cyc, a);
                end else begin
                    exp_x = q.pop_front();
                    if (a !== exp_x) begin n_err++; $display("FAIL rand_a: cycle %0d got %h expected %h", cyc, a, exp_x); end
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back(x);
                n_in++;
            end
        end
        @(negedge CLK);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            #1;
            if (out_valid) begin
                n_vec++;
                exp_x = q.pop_front();
                if (a !== exp_x) begin n_err++; $display("FAIL rand_drain_a: got %h expected %h", a, exp_x); end
                n_out++;
            end
            @(negedge CLK);
        end
        n_vec++; if (n_in !== n_out) begin n_err++; $display("FAIL rand_count: got out=%0d expected in=%0d", n_out, n_in); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_full_shift();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
